// File: rtl/prim_cipher_pkg.sv
// Shared cipher primitives: PRESENT 4-bit S-boxes plus the substitution/permutation
// round functions and FSM encoding used by the round-serial diffusion block.
package prim_cipher_pkg;

    localparam int SpMaxWidth = 256;

    typedef logic [SpMaxWidth-1:0]         sp_vec_t;
    typedef logic [$clog2(SpMaxWidth)-1:0] sp_idx_t;

    localparam logic [15:0][3:0] PRESENT_SBOX4 = {
        4'h2, 4'h1, 4'h7, 4'h4, 4'h8, 4'hF, 4'hE, 4'h3,
        4'hD, 4'hA, 4'h0, 4'h9, 4'hB, 4'h6, 4'h5, 4'hC
    };

    localparam logic [15:0][3:0] PRESENT_SBOX4_INV = {
        4'hA, 4'h9, 4'h7, 4'h0, 4'h3, 4'h6, 4'h4, 4'hB,
        4'hD, 4'h2, 4'h1, 4'hC, 4'h8, 4'hF, 4'hE, 4'h5
    };

    typedef enum logic [1:0] {
        SpIdle = 2'd0,
        SpRun  = 2'd1,
        SpDone = 2'd2
    } sp_iter_state_e;

    // Vectors are carried zero-padded to SpMaxWidth; only the low `width` bits are meaningful.
    function automatic sp_vec_t sp_enc_round(input sp_vec_t state, input sp_vec_t key,
                                             input int width);
        sp_vec_t x, y, z;
        x = state ^ key;
        for (int k = 0; k < SpMaxWidth / 4; k++) begin
            if (k < width / 4) begin
                x[sp_idx_t'(4 * k) +: 4] = PRESENT_SBOX4[x[sp_idx_t'(4 * k) +: 4]];
            end
        end
        y = '0;
        for (int k = 0; k < SpMaxWidth; k++) begin
            if (k < width) y[sp_idx_t'(width - 1 - k)] = x[sp_idx_t'(k)];
        end
        z = '0;
        for (int k = 0; k < SpMaxWidth / 2; k++) begin
            if (k < width / 2) begin
                z[sp_idx_t'(k)]             = y[sp_idx_t'(2 * k)];
                z[sp_idx_t'(k + width / 2)] = y[sp_idx_t'(2 * k + 1)];
            end
        end
        if ((width % 2) == 1) z[sp_idx_t'(width - 1)] = y[sp_idx_t'(width - 1)];
        return z;
    endfunction

    function automatic sp_vec_t sp_dec_round(input sp_vec_t state, input sp_vec_t key,
                                             input int width);
        sp_vec_t x, y, z;
        x = state ^ key;
        y = '0;
        for (int k = 0; k < SpMaxWidth / 2; k++) begin
            if (k < width / 2) begin
                y[sp_idx_t'(2 * k)]     = x[sp_idx_t'(k)];
                y[sp_idx_t'(2 * k + 1)] = x[sp_idx_t'(k + width / 2)];
            end
        end
        if ((width % 2) == 1) y[sp_idx_t'(width - 1)] = x[sp_idx_t'(width - 1)];
        z = '0;
        for (int k = 0; k < SpMaxWidth; k++) begin
            if (k < width) z[sp_idx_t'(width - 1 - k)] = y[sp_idx_t'(k)];
        end
        for (int k = 0; k < SpMaxWidth / 4; k++) begin
            if (k < width / 4) begin
                z[sp_idx_t'(4 * k) +: 4] = PRESENT_SBOX4_INV[z[sp_idx_t'(4 * k) +: 4]];
            end
        end
        return z;
    endfunction

endpackage

// File: rtl/prim_subst_perm_round.sv
// Combinational stage applying RoundsPerCycle substitution/permutation rounds,
// direction chosen at run time.
module prim_subst_perm_round
    import prim_cipher_pkg::*;
#(
    parameter int DataWidth      = 64,
    parameter int RoundsPerCycle = 1
) (
    input  logic [DataWidth-1:0] state,
    input  logic [DataWidth-1:0] key,
    input  logic                 decrypt,
    output logic [DataWidth-1:0] result
);

    if (DataWidth > SpMaxWidth || DataWidth < 2) begin : g_width_check
        $error("DataWidth out of supported range");
    end

    sp_vec_t acc;
    sp_vec_t key_ext;

    assign key_ext = SpMaxWidth'(key);

    always_comb begin
        acc = SpMaxWidth'(state);
        for (int r = 0; r < RoundsPerCycle; r++) begin
            acc = decrypt ? sp_dec_round(acc, key_ext, DataWidth)
                          : sp_enc_round(acc, key_ext, DataWidth);
        end
        result = acc[DataWidth-1:0];
    end

endmodule

// File: rtl/prim_subst_perm_iter.sv
// Round-serial, handshaked substitution/permutation diffusion: RoundsPerCycle rounds
// per clock on a captured state/key, result held until accepted.
module prim_subst_perm_iter
    import prim_cipher_pkg::*;
#(
    parameter int DataWidth      = 64,
    parameter int NumRounds      = 31,
    parameter int RoundsPerCycle = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 decrypt_i,
    input  logic [DataWidth-1:0] data_i,
    input  logic [DataWidth-1:0] key_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DataWidth-1:0] data_o,
    output logic                 busy_o
);

    localparam int NumCycles = NumRounds / RoundsPerCycle;
    localparam int CntW      = $clog2(NumCycles + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(NumCycles - 1);

    if (NumRounds < 1 || RoundsPerCycle < 1 || (NumRounds % RoundsPerCycle) != 0) begin : g_param_check
        $error("RoundsPerCycle must divide NumRounds");
    end

    sp_iter_state_e fsm_q, fsm_d;

    logic [DataWidth-1:0] state_p0;
    logic [DataWidth-1:0] key_p0;
    logic                 mode_p0;
    logic [CntW-1:0]      cnt_p0;
    logic [DataWidth-1:0] round_out;
    logic                 accept;
    logic                 last;

    assign accept = req_valid_i & req_ready_o & ~clear_i;
    assign last   = (fsm_q == SpRun) && (cnt_p0 == LastCnt);

    prim_subst_perm_round #(
        .DataWidth      (DataWidth),
        .RoundsPerCycle (RoundsPerCycle)
    ) u_round (
        .state   (state_p0),
        .key     (key_p0),
        .decrypt (mode_p0),
        .result  (round_out)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) fsm_q <= SpIdle;
        else       fsm_q <= fsm_d;
    end

    always_comb begin
        fsm_d = fsm_q;
        if (clear_i) begin
            fsm_d = SpIdle;
        end else begin
            unique case (fsm_q)
                SpIdle:  if (req_valid_i) fsm_d = SpRun;
                SpRun:   if (cnt_p0 == LastCnt) fsm_d = SpDone;
                SpDone:  if (rsp_ready_i) fsm_d = req_valid_i ? SpRun : SpIdle;
                default: fsm_d = SpIdle;
            endcase
        end
    end

    // Ready depends on rsp_ready_i only, so upstream never sees a valid->ready loop.
    always_comb begin
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        busy_o      = 1'b0;
        unique case (fsm_q)
            SpIdle:  req_ready_o = 1'b1;
            SpRun:   busy_o      = 1'b1;
            SpDone: begin
                rsp_valid_o = 1'b1;
                req_ready_o = rsp_ready_i;
            end
            default: ;
        endcase
    end

    // --- capture / round iteration / result stage ---
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_p0 <= '0;
            key_p0   <= '0;
            mode_p0  <= 1'b0;
            cnt_p0   <= '0;
            data_o   <= '0;
        end else if (clear_i) begin
            state_p0 <= '0;
            key_p0   <= '0;
            mode_p0  <= 1'b0;
            cnt_p0   <= '0;
            data_o   <= '0;
        end else if (accept) begin
            state_p0 <= data_i;
            key_p0   <= key_i;
            mode_p0  <= decrypt_i;
            cnt_p0   <= '0;
        end else if (fsm_q == SpRun) begin
            state_p0 <= round_out;
            cnt_p0   <= cnt_p0 + 1'b1;
            if (last) data_o <= round_out ^ key_p0;
        end
    end

endmodule

// File: tb/tb_prim_subst_perm_iter.sv
// Directed/random bench for prim_subst_perm_iter: 4-bit single-round config,
// default config, and fully unrolled default config side by side.
module tb_prim_subst_perm_iter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, clr, no_clear;
    logic [63:0] din, kin;
    logic        dec_in;

    logic        d_req_valid, d_req_ready, d_rsp_valid, d_rsp_ready, d_busy;
    logic [63:0] d_out;
    logic        u_req_valid, u_req_ready, u_rsp_valid, u_rsp_ready, u_busy;
    logic [63:0] u_out;
    logic        c_req_valid, c_req_ready, c_rsp_valid, c_rsp_ready, c_busy, c_dec;
    logic [3:0]  c_data, c_key, c_out;

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] exp_q[$];

    logic [3:0] sb  [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                             4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
    logic [3:0] sbi [16] = '{4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
                             4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA};

    prim_subst_perm_iter dut_d (
        .clk_i(clk), .rst_i(rst), .clear_i(clr),
        .req_valid_i(d_req_valid), .req_ready_o(d_req_ready), .decrypt_i(dec_in),
        .data_i(din), .key_i(kin), .rsp_valid_o(d_rsp_valid), .rsp_ready_i(d_rsp_ready),
        .data_o(d_out), .busy_o(d_busy)
    );

    prim_subst_perm_iter #(.RoundsPerCycle(31)) dut_u (
        .clk_i(clk), .rst_i(rst), .clear_i(no_clear),
        .req_valid_i(u_req_valid), .req_ready_o(u_req_ready), .decrypt_i(dec_in),
        .data_i(din), .key_i(kin), .rsp_valid_o(u_rsp_valid), .rsp_ready_i(u_rsp_ready),
        .data_o(u_out), .busy_o(u_busy)
    );

    prim_subst_perm_iter #(.DataWidth(4), .NumRounds(1), .RoundsPerCycle(1)) dut_c (
        .clk_i(clk), .rst_i(rst), .clear_i(no_clear),
        .req_valid_i(c_req_valid), .req_ready_o(c_req_ready), .decrypt_i(c_dec),
        .data_i(c_data), .key_i(c_key), .rsp_valid_o(c_rsp_valid), .rsp_ready_i(c_rsp_ready),
        .data_o(c_out), .busy_o(c_busy)
    );

    // Reference: round composed as z[j] = x[w-1-2j], z[j+w/2] = x[w-2-2j] after the S-box layer.
    function automatic logic [63:0] ref_op(input logic [63:0] d, input logic [63:0] k,
                                           input int w, input int n, input bit dec);
        logic [63:0] x, t;
        logic [3:0]  nib;
        x = d;
        for (int r = 0; r < n; r++) begin
            x = x ^ k;
            t = '0;
            if (!dec) begin
                for (int i = 0; i < w / 4; i++) begin
                    nib = x[4*i +: 4];
                    x[4*i +: 4] = sb[nib];
                end
                for (int j = 0; j < w / 2; j++) begin
                    t[j]       = x[w-1-2*j];
                    t[j + w/2] = x[w-2-2*j];
                end
            end else begin
                for (int j = 0; j < w / 2; j++) begin
                    t[w-1-2*j] = x[j];
                    t[w-2-2*j] = x[j + w/2];
                end
                for (int i = 0; i < w / 4; i++) begin
                    nib = t[4*i +: 4];
                    t[4*i +: 4] = sbi[nib];
                end
            end
            x = t;
        end
        return x ^ k;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_req(input logic [63:0] d, input logic [63:0] k, input bit dec);
        din = d;
        kin = k;
        dec_in = dec;
        d_req_valid = 1'b1;
        exp_q.push_back(ref_op(d, k, 64, 31, dec));
    endtask

    // Drives one request from a negedge; returns at the negedge right after the handshake edge.
    task automatic issue(input logic [63:0] d, input logic [63:0] k, input bit dec);
        start_req(d, k, dec);
        @(negedge clk);
        d_req_valid = 1'b0;
        din = {$urandom, $urandom};
        kin = {$urandom, $urandom};
        dec_in = ~dec_in;
    endtask

    task automatic wait_rsp(input string tag, input int start_lat);
        int lat;
        logic [63:0] e;
        lat = start_lat;
        while (d_rsp_valid !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'd31);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        check({tag, " data"}, d_out, e);
    endtask

    initial begin
        logic [63:0] d, k, e, held;
        bit seen;

        rst = 1'b1; clr = 1'b0; no_clear = 1'b0;
        din = '0; kin = '0; dec_in = 1'b0;
        d_req_valid = 1'b0; d_rsp_ready = 1'b1;
        u_req_valid = 1'b0; u_rsp_ready = 1'b1;
        c_req_valid = 1'b0; c_rsp_ready = 1'b1; c_dec = 1'b0; c_data = '0; c_key = '0;
        #1;
        check("reset data_o", d_out, 64'h0);
        check("reset rsp_valid", d_rsp_valid, 1'b0);
        check("reset busy", d_busy, 1'b0);
        check("reset req_ready", d_req_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 4-bit single-round config: encrypt 0 -> 5, decrypt 5 -> 0
        c_req_valid = 1'b1; c_data = 4'h0; c_key = 4'h0; c_dec = 1'b0;
        check("c4 req_ready", c_req_ready, 1'b1);
        @(negedge clk);
        c_req_valid = 1'b0; c_data = 4'hF;
        check("c4 enc busy", c_busy, 1'b1);
        @(negedge clk);
        check("c4 enc rsp_valid", c_rsp_valid, 1'b1);
        check("c4 enc data", 64'(c_out), 64'(ref_op(64'h0, 64'h0, 4, 1, 1'b0)));
        check("c4 enc const", 64'(c_out), 64'h5);
        @(negedge clk);
        c_req_valid = 1'b1; c_data = 4'h5; c_key = 4'h0; c_dec = 1'b1;
        @(negedge clk);
        c_req_valid = 1'b0;
        @(negedge clk);
        check("c4 dec rsp_valid", c_rsp_valid, 1'b1);
        check("c4 dec data", 64'(c_out), 64'h0);
        @(negedge clk);

        // Random encrypt / decrypt pairs on the default config
        for (int i = 0; i < 150; i++) begin
            d = {$urandom, $urandom};
            k = {$urandom, $urandom};
            check("rand idle ready", d_req_ready, 1'b1);
            issue(d, k, 1'b0);
            wait_rsp("enc", 0);
            e = d_out;
            @(negedge clk);
            issue(e, k, 1'b1);
            wait_rsp("dec", 0);
            check("roundtrip", d_out, d);
            @(negedge clk);
        end

        // Unrolled vs serial on identical stimulus
        d = 64'h0123_4567_89AB_CDEF;
        k = 64'hFEDC_BA98_7654_3210;
        start_req(d, k, 1'b0);
        u_req_valid = 1'b1;
        check("unrolled ready", u_req_ready, 1'b1);
        @(negedge clk);
        d_req_valid = 1'b0; u_req_valid = 1'b0;
        din = '0; kin = '0;
        check("unrolled busy", u_busy, 1'b1);
        @(negedge clk);
        check("unrolled latency1 valid", u_rsp_valid, 1'b1);
        e = u_out;
        check("unrolled data", e, ref_op(d, k, 64, 31, 1'b0));
        wait_rsp("serial vs unrolled", 1);
        check("unrolled equals serial", d_out, e);
        @(negedge clk);

        // Backpressure: hold rsp_ready low for 10 cycles, then back-to-back accept
        d_rsp_ready = 1'b0;
        issue({$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
        wait_rsp("hold", 0);
        held = d_out;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold data", d_out, held);
            check("hold valid", d_rsp_valid, 1'b1);
            check("hold req_ready", d_req_ready, 1'b0);
        end
        d_rsp_ready = 1'b1;
        start_req({$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
        #1;
        check("b2b req_ready", d_req_ready, 1'b1);
        @(negedge clk);
        d_req_valid = 1'b0;
        check("b2b busy", d_busy, 1'b1);
        check("b2b rsp_valid low", d_rsp_valid, 1'b0);
        wait_rsp("b2b", 0);
        @(negedge clk);

        // clear_i at Run cycle 15, with a competing request
        issue({$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
        repeat (15) @(negedge clk);
        clr = 1'b1;
        din = {$urandom, $urandom};
        d_req_valid = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        d_req_valid = 1'b0;
        void'(exp_q.pop_back());
        check("clear busy", d_busy, 1'b0);
        check("clear rsp_valid", d_rsp_valid, 1'b0);
        check("clear data_o", d_out, 64'h0);
        check("clear req_ready", d_req_ready, 1'b1);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (d_rsp_valid === 1'b1) seen = 1'b1;
        end
        check("clear no late rsp", 64'(seen), 64'h0);
        issue({$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
        wait_rsp("after clear", 0);
        @(negedge clk);

        // Asynchronous reset mid-Run (cycle 7)
        issue({$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
        repeat (7) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst run data_o", d_out, 64'h0);
        check("rst run rsp_valid", d_rsp_valid, 1'b0);
        check("rst run busy", d_busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        void'(exp_q.pop_back());
        check("rst run req_ready", d_req_ready, 1'b1);

        // Asynchronous reset mid-Done
        d_rsp_ready = 1'b0;
        issue({$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
        wait_rsp("pre rst done", 0);
        #2 rst = 1'b1;
        #1;
        check("rst done data_o", d_out, 64'h0);
        check("rst done rsp_valid", d_rsp_valid, 1'b0);
        check("rst done busy", d_busy, 1'b0);
        check("rst done u data_o", u_out, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        d_rsp_ready = 1'b1;
        check("rst done req_ready", d_req_ready, 1'b1);
        check("rst c4 req_ready", c_req_ready, 1'b1);

        // 4-bit config after reset: key 0, data 0 -> 5
        c_req_valid = 1'b1; c_data = 4'h0; c_key = 4'h0; c_dec = 1'b0;
        @(negedge clk);
        c_req_valid = 1'b0;
        @(negedge clk);
        check("post rst c4 valid", c_rsp_valid, 1'b1);
        check("post rst c4 data", 64'(c_out), 64'h5);
        @(negedge clk);

        check("scoreboard empty", 64'(exp_q.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
